// File: rtl/gate_seq_pkg.sv
// ----------------------------------------------------------------------------
// gate_seq_pkg
// Shared types and constants for the gate truth-table sequencer.
//   - state_e      : sequencer FSM states
//   - N_VEC/IDX_W  : number of input vectors for a 2-input gate and index width
//   - ERR_W        : width of the mismatch counter (holds 0..4)
//   - CNT_W        : width of the settle counter (settle values 0..15)
//   - TT_*         : expected truth tables, bit i = f for {a,b} = i
// ----------------------------------------------------------------------------
package gate_seq_pkg;

    localparam int N_VEC = 4;
    localparam int IDX_W = 2;
    localparam int ERR_W = 3;
    localparam int CNT_W = 4;

    localparam logic [N_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [N_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [N_VEC-1:0] TT_XOR  = 4'b0110;
    localparam logic [N_VEC-1:0] TT_NAND = 4'b0111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WAIT   = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// ----------------------------------------------------------------------------
// tt_settle_timer
// Load/decrement down-counter used to hold the sequencer in its settle state.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset (counter -> 0)
//   load     in  load load_val this cycle (has priority over dec)
//   load_val in  value to load
//   dec      in  decrement this cycle (saturates at 0)
//   last     out high while the counter holds its final count (1, or 0)
// ----------------------------------------------------------------------------
module tt_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The wait state is only entered with a nonzero load, so the count
    // normally exits at 1. Treating 0 as "last" too means a corrupted count
    // can never strand the FSM in its wait state.
    assign last = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// ----------------------------------------------------------------------------
// gate_tt_sequencer
// Drives a 2-input combinational gate-under-test through vectors 00,01,10,11.
// After each vector it waits SETTLE_CYC cycles, samples gut_f, and compares it
// with EXPECT_TT. At the end of a run it pulses done and reports pass/err_cnt.
//
// Parameters:
//   SETTLE_CYC  wait cycles after applying a vector (0..15)
//   EXPECT_TT   expected truth table, bit i = f for {a,b} = i
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   run request, only honoured in IDLE
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse when a run completes
//   pass     out  last completed run had zero mismatches
//   err_cnt  out  mismatch count of current/last run (0..4)
//   gut_a    out  registered GUT input a
//   gut_b    out  registered GUT input b
//   gut_f    in   GUT output
//   obs_tt   out  observed truth table
//
// Build option: define TT_SEQ_CAPTURE_EN to capture gut_f into obs_tt during
// each check. Without it obs_tt is tied to 0 and no capture flops exist.
// ----------------------------------------------------------------------------
module gate_tt_sequencer
    import gate_seq_pkg::*;
#(
    parameter int               SETTLE_CYC = 2,
    parameter logic [N_VEC-1:0] EXPECT_TT  = TT_AND
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             gut_a,
    output logic             gut_b,
    input  logic             gut_f,
    output logic [N_VEC-1:0] obs_tt
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam bit               HAS_WAIT  = (SETTLE_CYC > 0);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic             pass_q;
    logic             pass_d;
    logic             gut_a_q;
    logic             gut_a_d;
    logic             gut_b_q;
    logic             gut_b_d;

    logic             timer_load;
    logic             timer_dec;
    logic             timer_last;
    logic             mismatch;

    // ------------------------------------------------------------------
    // Settle timer: loaded in APPLY, counts down in WAIT
    // ------------------------------------------------------------------
    assign timer_load = (state_q == APPLY);
    assign timer_dec  = (state_q == WAIT);

    tt_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LD),
        .dec      (timer_dec),
        .last     (timer_last)
    );

    // gut_a/gut_b are registered copies of idx, so in CHECK gut_f belongs to
    // the vector selected by idx_q.
    assign mismatch = (gut_f != EXPECT_TT[idx_q]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = HAS_WAIT ? WAIT : CHECK;
            end
            WAIT: begin
                if (timer_last) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = (idx_q == IDX_W'(N_VEC - 1)) ? FINISH : APPLY;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        gut_a_d   = gut_a_q;
        gut_b_d   = gut_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                end
            end
            APPLY: begin
                gut_a_d = idx_q[1];
                gut_b_d = idx_q[0];
            end
            CHECK: begin
                // At most N_VEC increments per run, so ERR_W bits never wrap.
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                if (idx_q != IDX_W'(N_VEC - 1)) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FINISH: begin
                // err_cnt_q already includes the last CHECK's increment.
                pass_d  = (err_cnt_q == '0);
                gut_a_d = 1'b0;
                gut_b_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            gut_a_q   <= 1'b0;
            gut_b_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            gut_a_q   <= gut_a_d;
            gut_b_q   <= gut_b_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;
    assign gut_a   = gut_a_q;
    assign gut_b   = gut_b_q;

    // ------------------------------------------------------------------
    // Optional observed truth-table capture
    // ------------------------------------------------------------------
`ifdef TT_SEQ_CAPTURE_EN
    logic [N_VEC-1:0] obs_tt_q;
    logic [N_VEC-1:0] obs_tt_d;

    always_comb begin
        obs_tt_d = obs_tt_q;
        if ((state_q == IDLE) && start) begin
            obs_tt_d = '0;
        end else if (state_q == CHECK) begin
            obs_tt_d[idx_q] = gut_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            obs_tt_q <= '0;
        end else begin
            obs_tt_q <= obs_tt_d;
        end
    end

    assign obs_tt = obs_tt_q;
`else
    assign obs_tt = '0;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gate_tt_sequencer
// Two sequencer instances: u_dut_a (SETTLE_CYC=2) and u_dut_b (SETTLE_CYC=0),
// both expecting an AND gate. A behavioural gate model, selected by gate_mode,
// stands in for the GUT. Cycle 0 is the cycle in which start is sampled.
// ----------------------------------------------------------------------------
module tb_gate_tt_sequencer;
    import gate_seq_pkg::*;

`ifdef TT_SEQ_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    localparam int M_AND   = 0;
    localparam int M_STUCK = 1;
    localparam int M_OR    = 2;
    localparam int M_XOR   = 3;
    localparam int M_NAND  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    int         gate_mode = M_AND;
    int         cur_sel = 0;

    logic       busy_a, done_a, pass_a, gut_a_a, gut_b_a, gut_f_a;
    logic [2:0] err_a;
    logic [3:0] obs_a;
    logic       busy_b, done_b, pass_b, gut_a_b, gut_b_b, gut_f_b;
    logic [2:0] err_b;
    logic [3:0] obs_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            M_AND:   return a & b;
            M_STUCK: return 1'b0;
            M_OR:    return a | b;
            M_XOR:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    always_comb gut_f_a = gate_model(gate_mode, gut_a_a, gut_b_a);
    always_comb gut_f_b = gate_model(gate_mode, gut_a_b, gut_b_b);

    gate_tt_sequencer #(.SETTLE_CYC(2), .EXPECT_TT(TT_AND)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .gut_a(gut_a_a), .gut_b(gut_b_a),
        .gut_f(gut_f_a), .obs_tt(obs_a)
    );

    gate_tt_sequencer #(.SETTLE_CYC(0), .EXPECT_TT(TT_AND)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .gut_a(gut_a_b), .gut_b(gut_b_b),
        .gut_f(gut_f_b), .obs_tt(obs_b)
    );

    // Outputs of whichever instance the current test targets
    logic       m_busy, m_done, m_pass;
    logic [1:0] m_ab;
    logic [2:0] m_err;
    logic [3:0] m_obs;
    always_comb begin
        m_busy = (cur_sel == 1) ? busy_b : busy_a;
        m_done = (cur_sel == 1) ? done_b : done_a;
        m_pass = (cur_sel == 1) ? pass_b : pass_a;
        m_ab   = (cur_sel == 1) ? {gut_a_b, gut_b_b} : {gut_a_a, gut_b_a};
        m_err  = (cur_sel == 1) ? err_b : err_a;
        m_obs  = (cur_sel == 1) ? obs_b : obs_a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur_sel == 1) start_b = v;
        else              start_a = v;
    endtask

    typedef struct {
        string      name;
        int         mode;
        int         sel;
        int         done_cyc;
        int         err;
        logic       pas;
        logic [3:0] obs;
    } vec_t;

    vec_t vecs[7];

    // One full run: start pulse in cycle 0, gut vector checked in every CHECK
    // cycle, done cycle checked, then final status checked in the IDLE cycle.
    task automatic run_vec(input vec_t v);
        int  per;
        int  c;
        bit  seen;
        logic [3:0] exp_obs;
        cur_sel   = v.sel;
        gate_mode = v.mode;
        per       = (v.sel == 1) ? 2 : 4;
        exp_obs   = CAP ? v.obs : 4'b0000;
        seen      = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        c = 0;
        while (!seen && c < 60) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                set_start(1'b0);
                chk({v.name, " busy@1"}, 32'(m_busy), 32'd1);
            end
            if ((c % per == 0) && (c / per >= 1) && (c / per <= 4))
                chk({v.name, " vector"}, 32'(m_ab), 32'(c / per - 1));
            if (m_done) begin
                seen = 1'b1;
                chk({v.name, " done_cycle"}, 32'(c), 32'(v.done_cyc));
            end
        end
        if (!seen) chk({v.name, " done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({v.name, " done_pulse_len"}, 32'(m_done), 32'd0);
        chk({v.name, " busy_idle"}, 32'(m_busy), 32'd0);
        chk({v.name, " pass"}, 32'(m_pass), 32'(v.pas));
        chk({v.name, " err_cnt"}, 32'(m_err), 32'(v.err));
        chk({v.name, " obs_tt"}, 32'(m_obs), 32'(exp_obs));
        chk({v.name, " gut_ab_idle"}, 32'(m_ab), 32'd0);
        $display("run %s: done@%0d pass=%0d err_cnt=%0d obs_tt=%b",
                 v.name, c, m_pass, m_err, m_obs);
    endtask

    initial begin
        int ndone;
        int first_done;
        int c;

        vecs[0] = '{"and_s2",   M_AND,   0, 17, 0, 1'b1, 4'b1000};
        vecs[1] = '{"stuck_s2", M_STUCK, 0, 17, 1, 1'b0, 4'b0000};
        vecs[2] = '{"or_s2",    M_OR,    0, 17, 2, 1'b0, 4'b1110};
        vecs[3] = '{"xor_s2",   M_XOR,   0, 17, 3, 1'b0, 4'b0110};
        vecs[4] = '{"nand_s2",  M_NAND,  0, 17, 4, 1'b0, 4'b0111};
        vecs[5] = '{"and_s0",   M_AND,   1,  9, 0, 1'b1, 4'b1000};
        vecs[6] = '{"or_s0",    M_OR,    1,  9, 2, 1'b0, 4'b1110};

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy",   32'(busy_a), 32'd0);
        chk("rst done",   32'(done_a), 32'd0);
        chk("rst pass",   32'(pass_a), 32'd0);
        chk("rst err",    32'(err_a),  32'd0);
        chk("rst gut_ab", 32'({gut_a_a, gut_b_a}), 32'd0);
        chk("rst obs",    32'(obs_a),  32'd0);
        $display("reset check done");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // start re-pulsed at cycles 3 and 16 while busy: one done at 17
        cur_sel = 0; gate_mode = M_AND;
        @(negedge clk);
        start_a = 1'b1;
        ndone = 0; first_done = -1;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_a = (c == 3 || c == 16);
            if (done_a) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        start_a = 1'b0;
        chk("busy_start done_count", 32'(ndone), 32'd1);
        chk("busy_start done_cycle", 32'(first_done), 32'd17);
        chk("busy_start idle", 32'(busy_a), 32'd0);
        $display("run busy_start: done_count=%0d first_done=%0d", ndone, first_done);

        // Reset at cycle 10 of a run with a failing gate
        gate_mode = M_OR;
        @(negedge clk);
        start_a = 1'b1;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("pre_rst err", 32'(err_a), 32'd1);
        chk("pre_rst obs", 32'(obs_a), CAP ? 32'h2 : 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst busy",   32'(busy_a), 32'd0);
        chk("mid_rst done",   32'(done_a), 32'd0);
        chk("mid_rst pass",   32'(pass_a), 32'd0);
        chk("mid_rst err",    32'(err_a),  32'd0);
        chk("mid_rst gut_ab", 32'({gut_a_a, gut_b_a}), 32'd0);
        chk("mid_rst obs",    32'(obs_a),  32'd0);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a || busy_a) ndone++;
        end
        chk("post_rst quiet", 32'(ndone), 32'd0);
        $display("run mid_reset: outputs cleared, quiet cycles checked");

        // start held for 40 cycles: back-to-back runs, done at 17 and 35
        gate_mode = M_AND;
        @(negedge clk);
        start_a = 1'b1;
        ndone = 0;
        for (c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 40) start_a = 1'b0;
            if (done_a) begin
                ndone++;
                if (ndone == 1) chk("held done1_cycle", 32'(c), 32'd17);
                if (ndone == 2) chk("held done2_cycle", 32'(c), 32'd35);
            end
            if (c == 18) chk("held idle_gap", 32'(busy_a), 32'd0);
        end
        chk("held done_count", 32'(ndone), 32'd2);
        ndone = 0;
        for (c = 0; c < 40 && busy_a; c++) @(negedge clk);
        chk("held final_idle", 32'(busy_a), 32'd0);
        chk("held final_pass", 32'(pass_a), 32'd1);
        $display("run held_start: back-to-back runs checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
